// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: multicycle fetch/decode/exec/mem/wb sequencer for the accumulator datapath
//   clk, rst                           : clock, synchronous active-high reset
//   i_start, i_start_pc                : launch pulse and first instruction address
//   o_pc, i_instruction                : instruction fetch (async memory)
//   o_mem_*, i_mem_rdata               : data memory enable/rw/clear/address/write data, read data
//   o_reg_src*, i_reg_data*, o_reg_w*  : register file read selects/data, write strobe/select/data
//   o_alu_a/b/op, i_alu_result         : ALU operands, one-hot op, result
//   o_busy, o_halted, o_retired        : status and retired-instruction count
module acc_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int IMM_W = 25,
  parameter int PC_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_start_pc,
  output logic [DATA_W-1:0] o_pc,
  input  logic [31:0]       i_instruction,
  output logic              o_mem_en,
  output logic              o_mem_rw,
  output logic              o_mem_clear,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_reg_src1,
  output logic [1:0]        o_reg_src2,
  input  logic [DATA_W-1:0] i_reg_data1,
  input  logic [DATA_W-1:0] i_reg_data2,
  output logic              o_reg_we,
  output logic [1:0]        o_reg_wsel,
  output logic [DATA_W-1:0] o_reg_wdata,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [3:0]        o_alu_op,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_busy,
  output logic              o_halted,
  output logic [31:0]       o_retired
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_pc, r_a, r_r, w_imm;
  logic [31:0] r_ir, r_retired;
  logic [2:0] w_op;
  logic [1:0] w_fa, w_dest;
  logic w_retire, w_rd, w_wr, w_clr;
  assign w_op = r_ir[31:29];
  assign w_fa = r_ir[28:27];
  assign w_dest = r_ir[26:25];
  assign w_imm = DATA_W'(r_ir[IMM_W-1:0]);
  assign w_rd = r_state == S_MEM && w_op == 3'b110;
  assign w_wr = r_state == S_MEM && w_op == 3'b111;
  assign w_clr = r_state == S_MEM && w_op == 3'b100;
  // loads continue through WB; stores and clears retire straight out of MEM
  assign w_retire = r_state == S_WB || w_wr || w_clr;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = i_start ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = !w_op[2] ? S_EXEC : w_op == 3'b101 ? S_HALT : S_MEM;
      S_EXEC:   w_next = S_WB;
      S_MEM:    w_next = w_rd ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      default:  w_next = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc <= '0;
      r_ir <= '0;
      r_a <= '0;
      r_r <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) r_pc <= i_start_pc;
      else if (w_retire) r_pc <= r_pc + DATA_W'(PC_INC);
      if (w_retire) r_retired <= r_retired + 32'd1;
      if (r_state == S_FETCH) r_ir <= i_instruction;
      if (r_state == S_DECODE && !w_op[2]) r_a <= i_reg_data2;
      else if (r_state == S_DECODE && w_op == 3'b111) r_a <= i_reg_data1;
      if (r_state == S_EXEC) r_r <= i_alu_result;
      else if (w_rd) r_r <= i_mem_rdata;
    end
  end
  assign o_pc = r_pc;
  assign o_retired = r_retired;
  assign o_busy = r_state != S_IDLE && r_state != S_HALT;
  assign o_halted = r_state == S_HALT;
  assign o_reg_src1 = r_state == S_DECODE ? w_fa : 2'b00;
  assign o_reg_src2 = r_state == S_DECODE ? w_fa : 2'b00;
  assign o_alu_a = r_state == S_EXEC ? r_a : '0;
  assign o_alu_b = r_state == S_EXEC ? w_imm : '0;
  assign o_alu_op = r_state != S_EXEC ? 4'b0000 :
                    w_op[1:0] == 2'b00 ? 4'b1000 :
                    w_op[1:0] == 2'b01 ? 4'b0100 :
                    w_op[1:0] == 2'b10 ? 4'b0001 : 4'b0010;
  assign o_mem_en = w_rd || w_wr;
  assign o_mem_rw = w_wr;
  assign o_mem_clear = w_clr;
  assign o_mem_addr = r_state == S_MEM ? w_imm : '0;
  assign o_mem_wdata = w_wr ? r_a : '0;
  assign o_reg_we = r_state == S_WB;
  assign o_reg_wsel = r_state != S_WB ? 2'b00 : w_op == 3'b110 ? w_dest : 2'b10;
  assign o_reg_wdata = r_state == S_WB ? r_r : '0;
endmodule
